// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 16-bit multi-cycle load/store CPU:
//   - machine word width
//   - opcode encodings
//   - instruction field bit positions
//   - control FSM state encoding
//   - immediate sign-extension helper
// ----------------------------------------------------------------------------
package cpu_pkg;

    localparam int DATA_W = 16;

    // Opcodes, instruction bits [15:13]
    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_LOAD  = 3'b100;
    localparam logic [2:0] OP_STORE = 3'b101;
    localparam logic [2:0] OP_NOP   = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    // Field positions. rd (R-type) and r (M-type) share [12:11];
    // rs1 (R-type) and base (M-type) share [10:9].
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 13;
    localparam int RD_MSB  = 12;
    localparam int RD_LSB  = 11;
    localparam int RS1_MSB = 10;
    localparam int RS1_LSB = 9;
    localparam int RS2_MSB = 8;
    localparam int RS2_LSB = 7;
    localparam int IMM_MSB = 8;
    localparam int IMM_LSB = 0;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALTED
    } state_t;

    function automatic logic [DATA_W-1:0] sext_imm9(input logic [8:0] imm);
        return {{(DATA_W-9){imm[8]}}, imm};
    endfunction

endpackage

// File: rtl/cpu_mem_if.sv
// ----------------------------------------------------------------------------
// cpu_mem_if
// Single-port memory bus between the CPU datapath (master) and the unified
// instruction/data memory (slave).
//   addr  : word address (already reduced modulo memory depth)
//   wdata : store data
//   we    : write enable, sampled on the rising clock edge
//   rdata : asynchronous read data for addr
// ----------------------------------------------------------------------------
interface cpu_mem_if #(
    parameter int DATA_W = 16,
    parameter int AW     = 8
);
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] wdata;
    logic              we;
    logic [DATA_W-1:0] rdata;

    modport master (output addr, output wdata, output we, input  rdata);
    modport slave  (input  addr, input  wdata, input  we, output rdata);
endinterface

// File: rtl/cpu_memory.sv
// ----------------------------------------------------------------------------
// cpu_memory
// Unified word-addressed instruction/data memory.
// Ports:
//   clk : clock
//   bus : cpu_mem_if slave (async read of bus.addr, sync write when bus.we)
// ----------------------------------------------------------------------------
module cpu_memory #(
    parameter int DATA_W    = 16,
    parameter int MEM_DEPTH = 256
) (
    input logic      clk,
    cpu_mem_if.slave bus
);

    logic [DATA_W-1:0] mem [0:MEM_DEPTH-1];

    // NOTE: the array has no reset on purpose: preloaded program/data must
    // survive reset, and a resettable array would not map onto RAM.
    always_ff @(posedge clk) begin
        if (bus.we) mem[bus.addr] <= bus.wdata;
    end

    assign bus.rdata = mem[bus.addr];

endmodule

// File: rtl/cpu_regfile.sv
// ----------------------------------------------------------------------------
// cpu_regfile
// Four general-purpose registers (x0 is an ordinary register).
// Ports:
//   clk, reset            : clock, synchronous active-low reset (clears all)
//   i_raddr1 / o_rdata1   : asynchronous read port 1
//   i_raddr2 / o_rdata2   : asynchronous read port 2
//   i_we, i_waddr, i_wdata: synchronous write port
// ----------------------------------------------------------------------------
module cpu_regfile #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        i_raddr1,
    input  logic [1:0]        i_raddr2,
    output logic [DATA_W-1:0] o_rdata1,
    output logic [DATA_W-1:0] o_rdata2,
    input  logic              i_we,
    input  logic [1:0]        i_waddr,
    input  logic [DATA_W-1:0] i_wdata
);

    logic [DATA_W-1:0] regs [0:3];

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else if (i_we) begin
            regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = regs[i_raddr1];
    assign o_rdata2 = regs[i_raddr2];

endmodule

// File: rtl/processor_top.sv
// ----------------------------------------------------------------------------
// processor_top
// Minimal 16-bit multi-cycle load/store CPU. Executes one instruction at a
// time from the unified memory, starting at address 0.
// Ports:
//   clk   : system clock, all state changes on the rising edge
//   reset : synchronous active-low reset (PC/IR/latches/regs cleared,
//           memory untouched)
// Hierarchy: regfile (cpu_regfile), mem (cpu_memory).
// ----------------------------------------------------------------------------
module processor_top #(
    parameter int DATA_W    = 16,
    parameter int MEM_DEPTH = 256
) (
    input logic clk,
    input logic reset
);
    import cpu_pkg::*;

    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    // 16-bit address reduced modulo the memory depth; for a power-of-two
    // depth this collapses to keeping the low AW bits.
    function automatic logic [AW-1:0] to_addr(input logic [DATA_W-1:0] a);
        logic [31:0] m;
        m = 32'(a) % 32'(MEM_DEPTH);
        return m[AW-1:0];
    endfunction

    state_t            r_state;
    state_t            w_next_state;
    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_result;   // ALU result or effective address
    logic [DATA_W-1:0] r_mdr;      // load data

    logic [2:0]        w_op;
    logic              w_is_mem;
    logic [1:0]        w_raddr2;
    logic [DATA_W-1:0] w_rdata1;
    logic [DATA_W-1:0] w_rdata2;
    logic [DATA_W-1:0] w_exec_result;
    logic              w_rf_we;
    logic [DATA_W-1:0] w_rf_wdata;

    cpu_mem_if #(.DATA_W(DATA_W), .AW(AW)) mem_bus ();

    cpu_memory #(.DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH)) mem (
        .clk (clk),
        .bus (mem_bus.slave)
    );

    assign w_op     = r_ir[OP_MSB:OP_LSB];
    assign w_is_mem = (w_op == OP_LOAD) || (w_op == OP_STORE);
    // Second operand is rs2 for R-type, the data register r for M-type.
    assign w_raddr2 = w_is_mem ? r_ir[RD_MSB:RD_LSB] : r_ir[RS2_MSB:RS2_LSB];

    cpu_regfile #(.DATA_W(DATA_W)) regfile (
        .clk      (clk),
        .reset    (reset),
        .i_raddr1 (r_ir[RS1_MSB:RS1_LSB]),
        .i_raddr2 (w_raddr2),
        .o_rdata1 (w_rdata1),
        .o_rdata2 (w_rdata2),
        .i_we     (w_rf_we),
        .i_waddr  (r_ir[RD_MSB:RD_LSB]),
        .i_wdata  (w_rf_wdata)
    );

    always_comb begin
        unique case (w_op)
            OP_ADD:  w_exec_result = r_a + r_b;
            OP_SUB:  w_exec_result = r_a - r_b;
            OP_AND:  w_exec_result = r_a & r_b;
            OP_OR:   w_exec_result = r_a | r_b;
            default: w_exec_result = r_a + sext_imm9(r_ir[IMM_MSB:IMM_LSB]);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S_FETCH;
            r_pc     <= '0;
            r_ir     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_mdr    <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_FETCH: begin
                    r_ir <= mem_bus.rdata;
                    r_pc <= r_pc + 16'd1;
                end
                S_DECODE: begin
                    r_a <= w_rdata1;
                    r_b <= w_rdata2;
                end
                S_EXEC:  r_result <= w_exec_result;
                S_MEM:   if (w_op == OP_LOAD) r_mdr <= mem_bus.rdata;
                default: ;
            endcase
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_next_state  = r_state;
        mem_bus.addr  = to_addr(r_pc);
        mem_bus.wdata = r_b;
        mem_bus.we    = 1'b0;
        w_rf_we       = 1'b0;
        w_rf_wdata    = r_result;
        case (r_state)
            S_FETCH:  w_next_state = S_DECODE;
            S_DECODE: begin
                if (w_op == OP_NOP)       w_next_state = S_FETCH;
                else if (w_op == OP_HALT) w_next_state = S_HALTED;
                else                      w_next_state = S_EXEC;
            end
            S_EXEC:   w_next_state = w_is_mem ? S_MEM : S_WB;
            S_MEM: begin
                mem_bus.addr = to_addr(r_result);
                if (w_op == OP_STORE) begin
                    mem_bus.we   = 1'b1;
                    w_next_state = S_FETCH;
                end else begin
                    w_next_state = S_WB;
                end
            end
            S_WB: begin
                w_rf_we      = 1'b1;
                w_rf_wdata   = (w_op == OP_LOAD) ? r_mdr : r_result;
                w_next_state = S_FETCH;
            end
            default:  w_next_state = S_HALTED;
        endcase
    end

endmodule

// File: tb/tb_processor_top.sv
// ----------------------------------------------------------------------------
// tb_processor_top
// Directed bench for processor_top. Programs are written into dut.mem.mem
// while reset is held, registers are preloaded right after reset release,
// and outputs are sampled on the falling clock edge. The first rising edge
// after release is the FETCH edge of the instruction at address 0.
// ----------------------------------------------------------------------------
module tb_processor_top;
    import cpu_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    processor_top #(.DATA_W(16), .MEM_DEPTH(256)) dut (
        .clk   (clk),
        .reset (reset)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // n rising edges, then settle on the following falling edge
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    // Hold reset low for two edges and fill memory with NOP (0xC000).
    task automatic hold_reset();
        reset = 1'b0;
        step(2);
        for (int i = 0; i < 256; i++) dut.mem.mem[i] = 16'hC000;
    endtask

    initial begin
        // ---------------- reset state ----------------
        hold_reset();
        check("rst_pc",     dut.r_pc, 16'h0000);
        check("rst_ir",     dut.r_ir, 16'h0000);
        check("rst_state",  16'(dut.r_state), 16'(S_FETCH));
        check("rst_a",      dut.r_a, 16'h0000);
        check("rst_b",      dut.r_b, 16'h0000);
        check("rst_result", dut.r_result, 16'h0000);
        for (int i = 0; i < 4; i++) check($sformatf("rst_x%0d", i), dut.regfile.regs[i], 16'h0000);

        // ---------------- program 1: LOAD/ADD/SUB/STORE ----------------
        // 0x9003 LOAD x2,[x0+3]   = 100_10_00_000000011
        // 0x0D80 ADD  x1,x2,x3    = 000_01_10_11_0000000
        // 0x2380 SUB  x0,x1,x3    = 001_00_01_11_0000000
        // 0xB202 STORE x2,[x1+2]  = 101_10_01_000000010 (also the load data)
        dut.mem.mem[0] = 16'h9003;
        dut.mem.mem[1] = 16'h0D80;
        dut.mem.mem[2] = 16'h2380;
        dut.mem.mem[3] = 16'hB202;
        reset = 1'b1;
        dut.regfile.regs[3] = 16'h000A;
        step(4);
        check("p1_load_lat4", dut.regfile.regs[2], 16'h0000);
        step(1);
        check("p1_load_lat5", dut.regfile.regs[2], 16'hB202);
        step(3);
        check("p1_add_lat3", dut.regfile.regs[1], 16'h0000);
        step(1);
        check("p1_add_lat4", dut.regfile.regs[1], 16'hB20C);
        step(4);
        check("p1_sub", dut.regfile.regs[0], 16'hB202);
        step(3);
        check("p1_store_lat3", dut.mem.mem[8'h0E], 16'hC000);
        step(1);
        check("p1_store_lat4", dut.mem.mem[8'h0E], 16'hB202);
        step(23);
        check("p1_x0", dut.regfile.regs[0], 16'hB202);
        check("p1_x1", dut.regfile.regs[1], 16'hB20C);
        check("p1_x2", dut.regfile.regs[2], 16'hB202);
        check("p1_x3", dut.regfile.regs[3], 16'h000A);
        check("p1_mem0e", dut.mem.mem[8'h0E], 16'hB202);

        // ---------------- program 2: ending in HALT ----------------
        // Data sits past the HALT so it is never fetched as an instruction.
        hold_reset();
        dut.mem.mem[0] = 16'h9004;   // LOAD x2,[x0+4]
        dut.mem.mem[1] = 16'h0D80;
        dut.mem.mem[2] = 16'h2380;
        dut.mem.mem[3] = 16'hE000;   // HALT
        dut.mem.mem[4] = 16'h0005;
        reset = 1'b1;
        dut.regfile.regs[3] = 16'h000A;
        step(20);
        check("p2_x2", dut.regfile.regs[2], 16'h0005);
        check("p2_x1", dut.regfile.regs[1], 16'h000F);
        check("p2_x0", dut.regfile.regs[0], 16'h0005);
        check("p2_state", 16'(dut.r_state), 16'(S_HALTED));
        check("p2_pc", dut.r_pc, 16'h0004);
        step(10);
        check("p2_pc_frozen", dut.r_pc, 16'h0004);
        check("p2_state_stay", 16'(dut.r_state), 16'(S_HALTED));

        // ---------------- negative offset load ----------------
        hold_reset();
        dut.mem.mem[0]     = 16'h93FF;   // LOAD x2,[x1-1]
        dut.mem.mem[1]     = 16'hE000;
        dut.mem.mem[8'h0F] = 16'h1234;
        reset = 1'b1;
        dut.regfile.regs[1] = 16'h0010;
        step(5);
        check("neg_off_x2", dut.regfile.regs[2], 16'h1234);

        // ---------------- wrap-around arithmetic ----------------
        hold_reset();
        dut.mem.mem[0] = 16'h1B00;   // ADD x3,x1,x2
        dut.mem.mem[1] = 16'h2180;   // SUB x0,x0,x3
        dut.mem.mem[2] = 16'hE000;
        reset = 1'b1;
        dut.regfile.regs[1] = 16'hFFFF;
        dut.regfile.regs[2] = 16'h0002;
        step(3);
        check("wrap_add_lat3", dut.regfile.regs[3], 16'h0000);
        step(1);
        check("wrap_add", dut.regfile.regs[3], 16'h0001);
        step(4);
        check("wrap_sub", dut.regfile.regs[0], 16'hFFFF);

        // ---------------- reset in the middle of a LOAD ----------------
        hold_reset();
        dut.mem.mem[0] = 16'h9003;   // LOAD x2,[x0+3]
        dut.mem.mem[3] = 16'h5555;
        reset = 1'b1;
        step(2);
        check("mid_state_exec", 16'(dut.r_state), 16'(S_EXEC));
        reset = 1'b0;
        step(1);
        check("mid_x2", dut.regfile.regs[2], 16'h0000);
        check("mid_pc", dut.r_pc, 16'h0000);
        check("mid_ir", dut.r_ir, 16'h0000);
        check("mid_state", 16'(dut.r_state), 16'(S_FETCH));
        step(3);
        check("mid_x2_hold", dut.regfile.regs[2], 16'h0000);
        check("mid_mem_kept", dut.mem.mem[3], 16'h5555);
        reset = 1'b1;
        check("mid_pc_release", dut.r_pc, 16'h0000);
        step(5);
        check("mid_rerun_x2", dut.regfile.regs[2], 16'h5555);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
